complex_if_main: RTL and testbench

//   Hardware kernel for a small nested-if function:

---
 rtl/complex_if_main.sv | 120 ++++++++++++
 tb/tb_complex_if_main.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/complex_if_main.sv
// complex_if_main: nested-if kernel reading a 1-bit array through a synchronous read port.
// Optional MAIN_DONE_PULSE_EN makes w_enable a one-cycle pulse instead of a level held in DONE.
//   state | meaning
//   IDLE  | waiting for r_enable
//   RD0   | memory samples addr = i
//   EV0   | evaluate b0, finish or fetch arr[0]
//   RD1   | memory samples addr = 0
//   EV1   | evaluate b1, finish
//   DONE  | result valid, restart accepted
module complex_if_main #(
    parameter int ADDR_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r_enable,
    input  logic              controlArr,
    input  logic              init_i,
    output logic              controlArrWEnable_a,
    output logic [ADDR_W-1:0] controlArrAddr_a,
    input  logic              controlArrRData_a,
    output logic              controlArrWData_a,
    output logic              w_enable,
    output logic [1:0]        result
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        EV0  = 3'd2,
        RD1  = 3'd3,
        EV1  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              i_q, i_d;
    logic              ctrl_q, ctrl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [1:0]        result_q, result_d;

    logic start;
    logic bit_x;

    assign start = r_enable && (state_q == IDLE || state_q == DONE);
    assign bit_x = controlArrRData_a ^ ctrl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            i_q      <= 1'b0;
            ctrl_q   <= 1'b0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            result_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            ctrl_q   <= ctrl_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (r_enable) state_d = RD0;
            RD0:        state_d = EV0;
            EV0:        state_d = (!i_q || bit_x) ? DONE : RD1;
            RD1:        state_d = EV1;
            EV1:        state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        i_d      = i_q;
        ctrl_d   = ctrl_q;
        addr_d   = addr_q;
        result_d = result_q;
`ifdef MAIN_DONE_PULSE_EN
        wen_d    = 1'b0;
`else
        wen_d    = wen_q;
`endif
        if (start) begin
            i_d    = init_i;
            ctrl_d = controlArr;
            addr_d = ADDR_W'(init_i);
            wen_d  = 1'b0;
        end
        case (state_q)
            EV0: begin
                if (!i_q) begin
                    result_d = bit_x ? 2'd2 : 2'd0;
                    wen_d    = 1'b1;
                end else if (bit_x) begin
                    result_d = 2'd3;
                    wen_d    = 1'b1;
                end else begin
                    addr_d = '0;
                end
            end
            EV1: begin
                result_d = bit_x ? 2'd2 : 2'd1;
                wen_d    = 1'b1;
            end
            default: ;
        endcase
    end

    assign controlArrWEnable_a = 1'b0;
    assign controlArrWData_a   = 1'b0;
    assign controlArrAddr_a    = addr_q;
    assign w_enable            = wen_q;
    assign result              = result_q;

endmodule

// File: tb/tb_complex_if_main.sv
// Directed-vector bench for complex_if_main with a synchronous 2-entry read memory model.
module tb_complex_if_main;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r_enable = 1'b0;
    logic       controlArr = 1'b0;
    logic       init_i = 1'b0;
    logic       we_a;
    logic [0:0] addr_a;
    logic       rdata_a = 1'b0;
    logic       wdata_a;
    logic       w_enable;
    logic [1:0] result;

    logic       arr [2];
    int         n_vec = 0;
    int         n_bad = 0;

    complex_if_main #(.ADDR_W(1)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .r_enable            (r_enable),
        .controlArr          (controlArr),
        .init_i              (init_i),
        .controlArrWEnable_a (we_a),
        .controlArrAddr_a    (addr_a),
        .controlArrRData_a   (rdata_a),
        .controlArrWData_a   (wdata_a),
        .w_enable            (w_enable),
        .result              (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rdata_a <= arr[addr_a];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wen"},    8'(w_enable), 8'd0);
        chk({tag, "_result"}, 8'(result),   8'd0);
        chk({tag, "_addr"},   8'(addr_a),   8'd0);
        chk({tag, "_we"},     8'(we_a),     8'd0);
        chk({tag, "_wd"},     8'(wdata_a),  8'd0);
    endtask

    // Start one computation, scramble inputs afterwards, and measure latency in edges.
    task automatic run(input string tag, input logic i, input logic c,
                       input logic a1, input logic a0,
                       input logic [1:0] exp_r, input int exp_lat);
        logic [1:0] old_r;
        int         edges;
        arr[1] = a1;
        arr[0] = a0;
        @(negedge clk);
        old_r      = result;
        init_i     = i;
        controlArr = c;
        r_enable   = 1'b1;
        @(negedge clk);
        r_enable   = 1'b0;
        init_i     = ~i;
        controlArr = ~c;
        edges      = 1;
        chk({tag, "_addr_start"}, 8'(addr_a), 8'(i));
        while (!w_enable && edges < 10) begin
            chk({tag, "_hold"}, 8'(result), 8'(old_r));
            @(negedge clk);
            edges++;
        end
        chk({tag, "_latency"}, 8'(edges), 8'(exp_lat));
        chk({tag, "_result"},  8'(result), 8'(exp_r));
    endtask

    initial begin
        arr[0] = 1'b0;
        arr[1] = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run("i1_a1",     1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 3);
        run("i1_a0_1",   1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 5);
        chk("long_addr_end", 8'(addr_a), 8'd0);
        run("i1_a0_0",   1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 5);
        run("i0_a1",     1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 3);
        run("i0_a0",     1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3);
        run("c1_i0",     1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 3);
        run("c1_i1",     1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 5);

        // level mode: w_enable stays high in DONE
        repeat (3) @(negedge clk);
        chk("done_level", 8'(w_enable), 8'd1);
        chk("done_held",  8'(result),   8'd1);

        // r_enable while in EV0 must be ignored
        arr[1] = 1'b1;
        arr[0] = 1'b0;
        @(negedge clk);
        init_i = 1'b1; controlArr = 1'b0; r_enable = 1'b1;
        @(negedge clk);
        r_enable = 1'b0; init_i = 1'b0;
        @(negedge clk);
        r_enable = 1'b1;
        @(negedge clk);
        r_enable = 1'b0;
        chk("ev0_ignore_wen",    8'(w_enable), 8'd1);
        chk("ev0_ignore_result", 8'(result),   8'd3);
        repeat (3) @(negedge clk);
        chk("ev0_ignore_stay",   8'(w_enable), 8'd1);
        chk("ev0_ignore_addr",   8'(addr_a),   8'd1);

        // reset asserted while in RD1
        arr[1] = 1'b0;
        arr[0] = 1'b1;
        @(negedge clk);
        init_i = 1'b1; controlArr = 1'b0; r_enable = 1'b1;
        @(negedge clk);
        r_enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("rd1_wen_low", 8'(w_enable), 8'd0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset_idle_wen", 8'(w_enable), 8'd0);
        chk("post_reset_idle_res", 8'(result),   8'd0);
        run("after_reset", 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
